// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. Hits return the word combinationally;
// misses refill the whole line from backing memory, one word per memReady beat.
module instruction_cache #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic        flush,
   output logic [31:0] inst,
   output logic        hit,
   output logic        memReq,
   output logic [31:0] memAddr,
   input  logic        memReady,
   input  logic [31:0] memData,
   output logic [15:0] missCount,
   output logic        dbg_state
);

   localparam int OFF = $clog2(WORDS);
   localparam int IDX = $clog2(LINES);
   localparam int TAG = 30 - OFF - IDX;
   localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS - 1);

   typedef enum logic {IDLE, REFILL} state_t;

   state_t state_q, state_d;

   logic [31:0]    data_mem [LINES*WORDS];
   logic [TAG-1:0] tag_mem  [LINES];
   logic [LINES-1:0] valid_q;

   logic [TAG-1:0] fill_tag;
   logic [IDX-1:0] fill_idx;
   logic [OFF-1:0] beat_q;

   logic [TAG-1:0] tag_in;
   logic [IDX-1:0] idx_in;
   logic [OFF-1:0] off_in;
   logic           line_match;
   logic           miss;
   logic           last_beat;
   logic           unused_addr_bits;

   assign tag_in = addr[31 -: TAG];
   assign idx_in = addr[2+OFF +: IDX];
   assign off_in = addr[2 +: OFF];
   assign unused_addr_bits = ^addr[1:0];

   assign line_match = valid_q[idx_in] && (tag_mem[idx_in] == tag_in);
   assign miss       = req && !line_match;
   assign last_beat  = (beat_q == LAST_BEAT);

   // Hit is suppressed outside IDLE: the line being refilled may still look valid.
   assign hit       = req && line_match && (state_q == IDLE);
   assign inst      = hit ? data_mem[{idx_in, off_in}] : 32'd0;
   assign dbg_state = (state_q == REFILL);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (miss) state_d = REFILL;
            REFILL:  if (memReady && last_beat) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         valid_q   <= '0;
         beat_q    <= '0;
         fill_tag  <= '0;
         fill_idx  <= '0;
         memReq    <= 1'b0;
         memAddr   <= 32'd0;
         missCount <= 16'd0;
      end else if (flush) begin
         valid_q <= '0;
         beat_q  <= '0;
         memReq  <= 1'b0;
      end else if (state_q == IDLE) begin
         if (miss) begin
            fill_tag <= tag_in;
            fill_idx <= idx_in;
            beat_q   <= '0;
            memReq   <= 1'b1;
            memAddr  <= {tag_in, idx_in, {OFF{1'b0}}, 2'b00};
            if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
         end
      end else if (memReady) begin
         if (last_beat) begin
            valid_q[fill_idx] <= 1'b1;
            memReq            <= 1'b0;
         end else begin
            beat_q  <= beat_q + OFF'(1);
            memAddr <= memAddr + 32'd4;
         end
      end
   end

   // Storage arrays carry no reset; valid bits alone decide whether contents are used.
   always_ff @(posedge Clk) begin
      if (!flush && (state_q == REFILL) && memReady) begin
         data_mem[{fill_idx, beat_q}] <= memData;
         if (last_beat) tag_mem[fill_idx] <= fill_tag;
      end
   end

endmodule
